// File: rtl/memwb_pipe_reg_if.sv
// MEM/WB stage bundle: M-stage inputs, hold/bubble controls and W-stage outputs.
// Latency: none, wiring only.
// Backpressure: Stall holds the W stage; Flush overrides it and inserts a bubble.
interface memwb_pipe_reg_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  // M stage side
  logic              Valid_ToW;
  logic              WriteToReg_ToW;
  logic [SEL_W-1:0]  RegWriteDataSel_ToW;
  logic [REG_AW-1:0] WR_ToW;
  logic [DATA_W-1:0] ALUResult_ToW;
  logic [DATA_W-1:0] ReadData_ToW;
  logic [DATA_W-1:0] PCInc_ToW;
  logic              Halt_ToW;
  logic              Stall;
  logic              Flush;
  // W stage side
  logic              Valid_FromM;
  logic              WriteToReg_FromM;
  logic [SEL_W-1:0]  RegWriteDataSel_FromM;
  logic [REG_AW-1:0] WR_FromM;
  logic [DATA_W-1:0] ALUResult_FromM;
  logic [DATA_W-1:0] ReadData_FromM;
  logic [DATA_W-1:0] PCInc_FromM;
  logic              Halt_FromM;
  logic              HistValid;
  logic [REG_AW-1:0] HistWR;
  logic [DATA_W-1:0] HistData;
  logic [CNT_W-1:0]  RetireCount;

  modport master (
    output Valid_ToW, WriteToReg_ToW, RegWriteDataSel_ToW, WR_ToW,
           ALUResult_ToW, ReadData_ToW, PCInc_ToW, Halt_ToW, Stall, Flush,
    input  Valid_FromM, WriteToReg_FromM, RegWriteDataSel_FromM, WR_FromM,
           ALUResult_FromM, ReadData_FromM, PCInc_FromM, Halt_FromM,
           HistValid, HistWR, HistData, RetireCount
  );

  modport slave (
    input  Valid_ToW, WriteToReg_ToW, RegWriteDataSel_ToW, WR_ToW,
           ALUResult_ToW, ReadData_ToW, PCInc_ToW, Halt_ToW, Stall, Flush,
    output Valid_FromM, WriteToReg_FromM, RegWriteDataSel_FromM, WR_FromM,
           ALUResult_FromM, ReadData_FromM, PCInc_FromM, Halt_FromM,
           HistValid, HistWR, HistData, RetireCount
  );
endinterface

// File: rtl/memwb_pipe_reg.sv
// MEM/WB pipeline register with valid, hold/bubble, sticky halt, WB history and retire counter.
// Latency: 1 cycle from M-stage inputs to W-stage outputs; all outputs registered.
// Backpressure: Stall holds all fields (no retire); Flush wins over Stall and loads a bubble.
module memwb_pipe_reg #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  memwb_pipe_reg_if.slave    bus
);

  localparam logic [SEL_W-1:0] SelMem = SEL_W'(1);
  localparam logic [SEL_W-1:0] SelPc  = SEL_W'(2);

  logic              retire;
  logic [DATA_W-1:0] wbData;

  // The instruction in W leaves the stage whenever it is not held, or when flushed out.
  assign retire = bus.Valid_FromM & (~bus.Stall | bus.Flush);

  // Write-back value of the instruction currently in W; reserved select falls back to ALU.
  always_comb begin
    wbData = bus.ALUResult_FromM;
    if (bus.RegWriteDataSel_FromM == SelMem) begin
      wbData = bus.ReadData_FromM;
    end else if (bus.RegWriteDataSel_FromM == SelPc) begin
      wbData = bus.PCInc_FromM;
    end
  end

  // Pipeline fields, sticky halt, retire history and counter; reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.Valid_FromM           <= 1'b0;
      bus.WriteToReg_FromM      <= 1'b0;
      bus.RegWriteDataSel_FromM <= '0;
      bus.WR_FromM              <= '0;
      bus.ALUResult_FromM       <= '0;
      bus.ReadData_FromM        <= '0;
      bus.PCInc_FromM           <= '0;
      bus.Halt_FromM            <= 1'b0;
      bus.HistValid             <= 1'b0;
      bus.HistWR                <= '0;
      bus.HistData              <= '0;
      bus.RetireCount           <= '0;
    end else begin
      if (retire) begin
        if (bus.RetireCount != {CNT_W{1'b1}}) begin
          bus.RetireCount <= bus.RetireCount + CNT_W'(1);
        end
        if (bus.WriteToReg_FromM) begin
          bus.HistValid <= 1'b1;
          bus.HistWR    <= bus.WR_FromM;
          bus.HistData  <= wbData;
        end
      end
      if (bus.Flush) begin
        bus.Valid_FromM           <= 1'b0;
        bus.WriteToReg_FromM      <= 1'b0;
        bus.RegWriteDataSel_FromM <= '0;
        bus.WR_FromM              <= '0;
        bus.ALUResult_FromM       <= '0;
        bus.ReadData_FromM        <= '0;
        bus.PCInc_FromM           <= '0;
      end else if (!bus.Stall) begin
        bus.Valid_FromM           <= bus.Valid_ToW;
        bus.WriteToReg_FromM      <= bus.WriteToReg_ToW & bus.Valid_ToW;
        bus.RegWriteDataSel_FromM <= bus.RegWriteDataSel_ToW;
        bus.WR_FromM              <= bus.WR_ToW;
        bus.ALUResult_FromM       <= bus.ALUResult_ToW;
        bus.ReadData_FromM        <= bus.ReadData_ToW;
        bus.PCInc_FromM           <= bus.PCInc_ToW;
        if (bus.Valid_ToW && bus.Halt_ToW) begin
          bus.Halt_FromM <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/memwb_pipe_reg.md
Name: memwb_pipe_reg

Overview:
Parametrised MEM/WB pipeline register between the memory stage (M) and write-back stage (W) of the 5-stage WISC-SP13 pipeline. Adds the following beyond a plain flop bank:
- a valid bit
- stall (hold) and flush (bubble) controls
- a sticky halt capture
- a one-deep history of the last retired register write, for WB-to-ID forwarding
- a saturating retired-instruction counter for the performance/debug path.

Parameters:
DATA_W, 16, width of ALU result, memory read data and PC-increment fields
REG_AW, 3, register-file address width
SEL_W, 2, write-back data select width (0 ALU, 1 mem, 2 PC+2, 3 reserved, treated as ALU)
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
Valid_ToW  in  1  M stage holds a real instruction
WriteToReg_ToW  in  1  instruction writes register file
RegWriteDataSel_ToW  in  SEL_W  write-back source select
WR_ToW  in  REG_AW  destination register
ALUResult_ToW  in  DATA_W  ALU result
ReadData_ToW  in  DATA_W  data-memory read data
PCInc_ToW  in  DATA_W  PC+2 of instruction
Halt_ToW  in  1  instruction is HALT
Stall  in  1  hold all stage contents
Flush  in  1  replace next stage contents with a bubble
Valid_FromM  out  1  W stage holds a real instruction
WriteToReg_FromM  out  1  register write enable, already gated by Valid_FromM
RegWriteDataSel_FromM  out  SEL_W  registered select
WR_FromM  out  REG_AW  registered destination
ALUResult_FromM  out  DATA_W  registered ALU result
ReadData_FromM  out  DATA_W  registered read data
PCInc_FromM  out  DATA_W  registered PC+2
Halt_FromM  out  1  sticky halt
HistValid  out  1  history entry valid
HistWR  out  REG_AW  register written by previous retired instruction
HistData  out  DATA_W  value written by previous retired instruction
RetireCount  out  CNT_W  retired instructions, saturating

Behaviour:
- Update priority each rising edge: reset (rst==0) > Flush > Stall > load.
- Reset:
  - all outputs 0, including HistValid, HistWR, HistData, RetireCount and Halt_FromM
  - reset mid-operation discards the in-flight instruction; no retire or history update that cycle.
- Load (Flush=0, Stall=0):
  - every _ToW field is captured into its _FromM counterpart
  - Valid_FromM <= Valid_ToW
  - WriteToReg_FromM <= WriteToReg_ToW & Valid_ToW.
  - Latency is exactly 1 cycle.
- Stall=1, Flush=0:
  - all pipeline fields hold
  - no retire or history update, because the instruction has not left W.
- Flush=1:
  - Valid_FromM <= 0 and WriteToReg_FromM <= 0
  - data fields are don't-care but are cleared to 0
  - Flush overrides a simultaneous Stall.
- Retire event: Valid_FromM==1 and the stage is advancing (Stall==0 or Flush==1) on the edge. Each retire event:
  - RetireCount increments by 1, saturating at all-ones (no wrap)
  - if WriteToReg_FromM==1: HistValid <= 1, HistWR <= WR_FromM, HistData <= the write-back value selected by RegWriteDataSel_FromM (0 ALUResult, 1 ReadData, 2 PCInc, 3 ALUResult)
  - if WriteToReg_FromM==0: the history holds.
- A retire combined with a new load in the same cycle is legal; both updates happen on that edge.
- Halt:
  - Halt_FromM <= 1 on a load with Valid_ToW & Halt_ToW
  - once set, it stays 1 until reset, regardless of Flush or Stall.
- Valid_ToW==0 on load creates a bubble: no write, no count increment on the following retire.
- No combinational path from any input to any output; all outputs come from flops.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with random inputs -> all outputs 0; release rst=1 -> outputs still 0 until the first load edge.
2. Pass-through: load ALUResult=16'h1234, WR=3'd5, Sel=0, WriteToReg=1, Valid=1 -> next cycle ALUResult_FromM=16'h1234, WR_FromM=5, WriteToReg_FromM=1; following edge -> HistWR=5, HistData=16'h1234, HistValid=1, RetireCount=1.
3. Stall: load an instruction then assert Stall for 3 cycles with changing inputs -> outputs frozen, RetireCount unchanged; deassert -> one retire counted.
4. Flush vs stall: Flush=1 and Stall=1 together while a valid write is in W -> Valid_FromM=0, WriteToReg_FromM=0 next cycle; the flushed-out instruction still retires (count +1).
5. Select/history: Sel=1 with ReadData=16'hBEEF, then Sel=2 with PCInc=16'h0042, WriteToReg=0 -> HistData=16'hBEEF after the first retire and unchanged after the second; RetireCount +2.
6. Halt and saturation: CNT_W=4 build, retire 20 valid instructions -> RetireCount=4'hF; load Halt, then Flush -> Halt_FromM stays 1 until rst=0.
